reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  In-order ROB: the responder end of the decode-stage tag-allocation handshake (rob_pos).
//  Hands out the next free tag, records rd/op per entry and captures results from the write-back bus.
//  Retires the oldest completed entry each cycle to the register file.
//  Sits between decode (allocator), the execution units' write-back bus and the register file.
// PARAMETERS
//  DEPTH   7   number of entries; tags 1..DEPTH, tag 0 = `TAG_INVALID
//  TAG_W   3   tag width (`INST_TAG_WIDTH); must satisfy 2**TAG_W > DEPTH
//  DATA_W  32  result width (`COMMON_WIDTH)
//  REG_W   5   architectural register index width (`REG_NUM_WIDTH)
//  OP_W    -   op field width (`OP_TYPE_WIDTH)
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       reset; asynchronous, active-high
//  flush        in   1       synchronous clear of all entries
//  tag_token    in   1       decode requests an allocation this cycle
//  rd           in   REG_W   destination register of allocating instruction
//  op           in   OP_W    op type of allocating instruction
//  avail_tag    out  TAG_W   tag the next allocation receives; `TAG_INVALID when full
//  full         out  1       no free entry
//  wb_en        in   1       write-back bus valid
//  wb_tag       in   TAG_W   tag being completed
//  wb_val       in   DATA_W  result value
//  commit_en    out  1       registered; one entry retired this cycle
//  commit_tag   out  TAG_W   tag of retired entry
//  commit_rd    out  REG_W   destination of retired entry
//  commit_val   out  DATA_W  result of retired entry
// BEHAVIOUR
//  - Per entry: busy, ready, rd, op, val. State: head, tail (tags 1..DEPTH) and count (0..DEPTH).
//  - Reset (async) and flush (sync): all busy/ready=0, head=tail=1, count=0, commit_en=0,
//    commit_tag=`TAG_INVALID, commit_rd=0, commit_val=0.
//  - avail_tag/full combinational from state: full = (count==DEPTH); avail_tag = full ? `TAG_INVALID : tail.
//  - Allocate at posedge when tag_token && !full:
//    entry[tail] gets busy=1, ready=0, rd, op; tail advances. Wrap: DEPTH -> 1, never 0.
//  - tag_token while full: ignored, no state change. Decode must keep the instruction.
//  - Write-back at posedge when wb_en && wb_tag!=`TAG_INVALID && entry[wb_tag].busy:
//    val=wb_val, ready=1. Otherwise the write-back is ignored (stale tag after flush).
//  - Commit at posedge when entry[head].busy && entry[head].ready:
//    - register commit_en=1 with head's tag, rd and val; clear busy; head advances (same wrap rule).
//    - Otherwise commit_en=0 and the other commit_* fields hold their previous values.
//  - Latency: write-back to the head entry at edge N gives commit_en high after edge N+1.
//    Result readiness is never bypassed in the write-back cycle.
//  - Simultaneous events in one cycle:
//    - alloc+commit: count unchanged.
//    - alloc while full is blocked even if a commit frees an entry that edge.
//    - write-back and allocation target different entries by construction.
//  - Precedence: flush > commit/alloc/write-back. Reset mid-operation discards everything immediately.
//  - rd==0 is retired normally; the register file ignores writes to reg 0.
//  - count never exceeds DEPTH or underflows.
// STRUCTURE
//  - common_def.h: `TAG_INVALID (=0), widths.
//  - rob_pkg: rob_entry_t struct {busy, ready, rd, op, val}; next_tag() wrap function.
//  - Sub-module: rob_tag_ptr. Wrapping 1..DEPTH pointer with en and sync clear, instantiated for head and tail.
// TESTING
//  - Reset: assert rst mid-cycle -> avail_tag=1, full=0, commit_en=0 immediately.
//  - Allocate rd=3,5 (tags 1,2); wb tag2=0xB, then tag1=0xA -> commits in order:
//    tag1/rd3/0xA, then tag2/rd5/0xB, one per cycle.
//  - Fill 7 entries -> full=1, avail_tag=0; tag_token while full -> no change.
//    Commit tag1 and alloc in the same cycle -> alloc blocked; next cycle avail_tag=1 (wrap).
//  - Wrap: run 20 alloc/wb/commit triples -> tags cycle 1..7,1..; never 0 and never reused while busy.
//  - wb with tag 0 or a non-busy tag -> no effect; flush with 4 busy -> count=0;
//    a later wb to an old tag is ignored.
//  - Write-back to head at edge N -> commit_en at N+1, not N.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared widths, tag constants and the entry record for the in-order reorder buffer.
// Tags run 1..DEPTH; tag 0 is reserved to mean "no tag".
package rob_pkg;

    localparam int DEPTH  = 7;
    localparam int TAG_W  = 3;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int OP_W   = 4;

    typedef logic [TAG_W-1:0] tag_t;

    localparam tag_t TAG_INVALID = '0;
    localparam tag_t TAG_FIRST   = tag_t'(1);
    localparam tag_t TAG_LAST    = tag_t'(DEPTH);

    typedef struct packed {
        logic              busy;
        logic              ready;
        logic [REG_W-1:0]  rd;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] val;
    } rob_entry_t;

    // Successor of a tag, skipping the reserved tag 0 on wrap.
    function automatic tag_t next_tag(input tag_t t);
        return (t == TAG_LAST) ? TAG_FIRST : t + TAG_FIRST;
    endfunction

endpackage

// File: rtl/rob_tag_ptr.sv
// Wrapping tag pointer (1..DEPTH) with advance enable and synchronous clear back to tag 1.
module rob_tag_ptr
    import rob_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output tag_t ptr_o
);

    tag_t ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = TAG_FIRST;
        end else if (en_i) begin
            ptr_d = next_tag(ptr_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= TAG_FIRST;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocates tags to decode, captures write-back results,
// and retires the oldest completed entry per cycle through a registered commit port.
module reorder_buffer
    import rob_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              tag_token,
    input  logic [REG_W-1:0]  rd,
    input  logic [OP_W-1:0]   op,
    output logic [TAG_W-1:0]  avail_tag,
    output logic              full,
    input  logic              wb_en,
    input  logic [TAG_W-1:0]  wb_tag,
    input  logic [DATA_W-1:0] wb_val,
    output logic              commit_en,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [REG_W-1:0]  commit_rd,
    output logic [DATA_W-1:0] commit_val
);

    rob_entry_t        entry_q [1:DEPTH];
    tag_t              head_q, tail_q;
    tag_t              count_q, count_d;
    logic              alloc, wb_hit, commit;
    logic              commit_en_q;
    tag_t              commit_tag_q;
    logic [REG_W-1:0]  commit_rd_q;
    logic [DATA_W-1:0] commit_val_q;

    assign full      = (count_q == TAG_LAST);
    assign avail_tag = full ? TAG_INVALID : tail_q;

    // Allocation looks only at the registered count, so a commit on the same edge cannot unblock it.
    assign alloc  = tag_token && !full;
    assign wb_hit = wb_en && (wb_tag != TAG_INVALID) && (wb_tag <= TAG_LAST) && entry_q[wb_tag].busy;
    // Readiness comes from stored state only: a result arriving this edge retires on the next.
    assign commit = entry_q[head_q].busy && entry_q[head_q].ready;

    rob_tag_ptr u_head_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush),
        .en_i  (commit),
        .ptr_o (head_q)
    );

    rob_tag_ptr u_tail_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush),
        .en_i  (alloc),
        .ptr_o (tail_q)
    );

    always_comb begin
        count_d = count_q;
        case ({alloc, commit})
            2'b10:   count_d = count_q + TAG_FIRST;
            2'b01:   count_d = count_q - TAG_FIRST;
            default: count_d = count_q;
        endcase
        if (flush) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i <= DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 1; i <= DEPTH; i++) begin
                entry_q[i].busy  <= 1'b0;
                entry_q[i].ready <= 1'b0;
            end
        end else begin
            for (int i = 1; i <= DEPTH; i++) begin
                if (alloc && (tail_q == tag_t'(i))) begin
                    entry_q[i].busy  <= 1'b1;
                    entry_q[i].ready <= 1'b0;
                    entry_q[i].rd    <= rd;
                    entry_q[i].op    <= op;
                end
                if (wb_hit && (wb_tag == tag_t'(i))) begin
                    entry_q[i].val   <= wb_val;
                    entry_q[i].ready <= 1'b1;
                end
                if (commit && (head_q == tag_t'(i))) begin
                    entry_q[i].busy <= 1'b0;
                end
            end
        end
    end

    // Commit fields other than the enable hold their last retired values between commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_en_q  <= 1'b0;
            commit_tag_q <= TAG_INVALID;
            commit_rd_q  <= '0;
            commit_val_q <= '0;
        end else if (flush) begin
            commit_en_q  <= 1'b0;
            commit_tag_q <= TAG_INVALID;
            commit_rd_q  <= '0;
            commit_val_q <= '0;
        end else begin
            commit_en_q <= commit;
            if (commit) begin
                commit_tag_q <= head_q;
                commit_rd_q  <= entry_q[head_q].rd;
                commit_val_q <= entry_q[head_q].val;
            end
        end
    end

    assign commit_en  = commit_en_q;
    assign commit_tag = commit_tag_q;
    assign commit_rd  = commit_rd_q;
    assign commit_val = commit_val_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: a queue-based reference model predicts every retirement
// (tag, rd, value, edge) and a negedge monitor checks each commit the DUT presents.
module tb_reorder_buffer;
    import rob_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              tag_token = 1'b0;
    logic [REG_W-1:0]  rd = '0;
    logic [OP_W-1:0]   op = '0;
    logic [TAG_W-1:0]  avail_tag;
    logic              full;
    logic              wb_en = 1'b0;
    logic [TAG_W-1:0]  wb_tag = '0;
    logic [DATA_W-1:0] wb_val = '0;
    logic              commit_en;
    logic [TAG_W-1:0]  commit_tag;
    logic [REG_W-1:0]  commit_rd;
    logic [DATA_W-1:0] commit_val;

    reorder_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .tag_token  (tag_token),
        .rd         (rd),
        .op         (op),
        .avail_tag  (avail_tag),
        .full       (full),
        .wb_en      (wb_en),
        .wb_tag     (wb_tag),
        .wb_val     (wb_val),
        .commit_en  (commit_en),
        .commit_tag (commit_tag),
        .commit_rd  (commit_rd),
        .commit_val (commit_val)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    always @(posedge clk) edge_cnt++;

    typedef struct {int tag; int rd; bit rdy; logic [31:0] val;} ent_t;
    typedef struct {int tag; int rd; logic [31:0] val; int cyc;} exp_t;

    ent_t        rob_q[$];     // outstanding instructions, oldest first
    exp_t        exp_q[$];     // predicted retirements
    int          nxt = 1;      // tag the next allocation should receive
    int          m_tag = 0;
    int          m_rd = 0;
    logic [31:0] m_val = '0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endfunction

    function automatic void model_clear();
        rob_q.delete();
        nxt   = 1;
        m_tag = 0;
        m_rd  = 0;
        m_val = '0;
    endfunction

    // Monitor: every commit the DUT shows must match the oldest prediction, on the predicted edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && commit_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_commit actual=tag%0d required=none", commit_tag);
            end else begin
                e = exp_q.pop_front();
                $display("commit edge=%0d tag=%0d rd=%0d val=%08h", edge_cnt, commit_tag, commit_rd, commit_val);
                chk("commit_tag", 64'(commit_tag), 64'(e.tag));
                chk("commit_rd", 64'(commit_rd), 64'(e.rd));
                chk("commit_val", 64'(commit_val), 64'(e.val));
                chk("commit_edge", 64'(edge_cnt), 64'(e.cyc));
            end
        end
    end

    // One clock of stimulus: check visible state against the model, drive, then advance the model.
    task automatic step(input bit tok, input int rd_v, input bit we, input int wtag,
                        input logic [31:0] wv, input bit fl);
        bit can_alloc;
        @(negedge clk);
        chk("full", 64'(full), 64'(rob_q.size() == DEPTH));
        chk("avail_tag", 64'(avail_tag), 64'((rob_q.size() == DEPTH) ? 0 : nxt));
        chk("commit_tag_hold", 64'(commit_tag), 64'(m_tag));
        chk("commit_val_hold", 64'(commit_val), 64'(m_val));
        tag_token = tok;
        rd        = REG_W'(rd_v);
        op        = OP_W'($urandom);
        wb_en     = we;
        wb_tag    = TAG_W'(wtag);
        wb_val    = wv;
        flush     = fl;
        if (fl) begin
            model_clear();
        end else begin
            can_alloc = (rob_q.size() < DEPTH);
            if (rob_q.size() > 0 && rob_q[0].rdy) begin
                exp_q.push_back('{tag: rob_q[0].tag, rd: rob_q[0].rd, val: rob_q[0].val, cyc: edge_cnt + 1});
                m_tag = rob_q[0].tag;
                m_rd  = rob_q[0].rd;
                m_val = rob_q[0].val;
                void'(rob_q.pop_front());
            end
            if (we && wtag != 0) begin
                foreach (rob_q[i]) begin
                    if (rob_q[i].tag == wtag) begin
                        rob_q[i].rdy = 1'b1;
                        rob_q[i].val = wv;
                    end
                end
            end
            if (tok && can_alloc) begin
                rob_q.push_back('{tag: nxt, rd: rd_v, rdy: 1'b0, val: '0});
                nxt = (nxt == DEPTH) ? 1 : nxt + 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin : stim
        int wtag;
        bit we;
        // Power-up reset
        #12;
        chk("reset_avail_tag", 64'(avail_tag), 64'(1));
        chk("reset_full", 64'(full), 64'(0));
        chk("reset_commit_en", 64'(commit_en), 64'(0));
        chk("reset_commit_tag", 64'(commit_tag), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Two allocations, results arrive out of order, retire in order
        step(1, 3, 0, 0, '0, 0);
        step(1, 5, 0, 0, '0, 0);
        step(0, 0, 1, 2, 32'hB, 0);
        step(0, 0, 1, 1, 32'hA, 0);
        idle(4);

        // Fill from empty, hammer while full, then commit+alloc on the same edge
        step(0, 0, 0, 0, '0, 1);
        for (int i = 0; i < DEPTH; i++) step(1, i + 8, 0, 0, '0, 0);
        step(1, 20, 0, 0, '0, 0);
        step(1, 21, 1, 1, 32'h1111, 0);
        step(1, 22, 0, 0, '0, 0);
        step(0, 0, 0, 0, '0, 0);
        for (int t = 2; t <= DEPTH; t++) step(0, 0, 1, t, 32'h100 + t, 0);
        idle(10);

        // Ignored write-backs, flush with four busy, stale write-back afterwards
        for (int i = 1; i <= 4; i++) step(1, i, 0, 0, '0, 0);
        step(0, 0, 1, 0, 32'hDEAD, 0);
        step(0, 0, 1, 6, 32'hBEEF, 0);
        step(0, 0, 0, 0, '0, 1);
        step(0, 0, 1, 2, 32'hCAFE, 0);
        idle(4);

        // Wrap: 20 single-instruction alloc / write-back / commit triples
        for (int i = 0; i < 20; i++) begin
            wtag = nxt;
            step(1, i, 0, 0, '0, 0);
            step(0, 0, 1, wtag, $urandom, 0);
            step(0, 0, 0, 0, '0, 0);
        end
        idle(3);

        // Asynchronous reset in the middle of a cycle with work outstanding
        for (int i = 0; i < 3; i++) step(1, i + 1, 0, 0, '0, 0);
        step(0, 0, 1, rob_q[0].tag, 32'h77, 0);
        @(posedge clk);
        tag_token = 1'b0;
        wb_en     = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midreset_avail_tag", 64'(avail_tag), 64'(1));
        chk("midreset_full", 64'(full), 64'(0));
        chk("midreset_commit_en", 64'(commit_en), 64'(0));
        model_clear();
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            we = ($urandom_range(0, 99) < 70);
            if (rob_q.size() > 0 && $urandom_range(0, 99) < 75)
                wtag = rob_q[$urandom_range(0, rob_q.size() - 1)].tag;
            else
                wtag = $urandom_range(0, 7);
            step($urandom_range(0, 99) < 60, $urandom_range(0, 31), we, wtag, $urandom,
                 $urandom_range(0, 99) < 3);
        end

        // Complete everything left and drain
        while (rob_q.size() > 0 && !rob_q[rob_q.size() - 1].rdy) begin
            foreach (rob_q[i]) begin
                if (!rob_q[i].rdy) begin
                    wtag = rob_q[i].tag;
                    break;
                end
            end
            step(0, 0, 1, wtag, $urandom, 0);
        end
        idle(DEPTH + 4);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
